// File: rtl/up_down_counter8.sv
// Free-running modulo-2^WIDTH up/down counter with asynchronous active-high reset.
// The output is driven straight from the count register.
module up_down_counter8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             up_down,
  output logic [WIDTH-1:0] out
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Wrap-around in both directions falls out of the fixed-width arithmetic.
  always_comb begin
    count_d = count_q;
    if (up_down) begin
      count_d = count_q + ONE;
    end else begin
      count_d = count_q - ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign out = count_q;

endmodule

// File: tb/tb_up_down_counter8.sv
// Directed bench for up_down_counter8: reset, full-range up/down runs,
// wrap-around, direction toggling and reset release.
module tb_up_down_counter8;

  logic       clk;
  logic       reset;
  logic       up_down;
  logic [7:0] out;

  int vectors;
  int miscompares;

  up_down_counter8 #(.WIDTH(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .up_down (up_down),
    .out     (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [7:0] want);
    vectors++;
    assert (out === want)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: out=%h expected=%h", tag, out, want);
    end
  endtask

  // Called at a falling edge: set direction, let one rising edge pass, check at the next falling edge.
  task automatic apply_stimulus(input logic dir, input logic [7:0] want, input string tag);
    up_down = dir;
    @(posedge clk);
    @(negedge clk);
    check_output(tag, want);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    up_down     = 1'b1;

    @(negedge clk);
    @(negedge clk);
    check_output("reset_state", 8'h00);

    // Count up through the full range from 0 to 8'hFF.
    reset = 1'b0;
    for (int i = 1; i <= 255; i++) begin
      apply_stimulus(1'b1, 8'(i), "count_up");
    end
    check_output("reached_top", 8'hFF);

    // Turn around at the top and count all the way back down.
    apply_stimulus(1'b0, 8'hFE, "turnaround_top");
    for (int i = 2; i <= 255; i++) begin
      apply_stimulus(1'b0, 8'(255 - i), "count_down");
    end
    check_output("reached_bottom", 8'h00);

    apply_stimulus(1'b0, 8'hFF, "wrap_down");
    apply_stimulus(1'b1, 8'h00, "wrap_up");

    for (int i = 1; i <= 16; i++) begin
      apply_stimulus(1'b1, 8'(i), "climb_to_10");
    end

    // Alternate direction every edge around 8'h10.
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) begin
        apply_stimulus(1'b1, 8'h11, "toggle_up");
      end else begin
        apply_stimulus(1'b0, 8'h10, "toggle_down");
      end
    end

    for (int i = 8'h11; i <= 8'h37; i++) begin
      apply_stimulus(1'b1, 8'(i), "climb_to_37");
    end
    check_output("at_37", 8'h37);

    // Assert reset between edges; the clear must not wait for a clock.
    #2 reset = 1'b1;
    #1 check_output("async_clear", 8'h00);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output("reset_hold", 8'h00);
    end

    reset = 1'b0;
    apply_stimulus(1'b0, 8'hFF, "release_down");
    apply_stimulus(1'b0, 8'hFE, "release_down2");
    apply_stimulus(1'b1, 8'hFF, "release_up");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
